// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus CPU datapath with 16 GPRs, PC, IR, MAR, MDR, Y,
// 64-bit Z, HI, LO, ALU, select/encode logic, CON flip-flop and an internal RAM.
// Each cycle is steered by one-hot strobes from the control unit.
// Optional feature macro: ALU_MULDIV_EN enables signed MUL/DIV in the ALU.
// The IR field positions and the 5-bit shift amount assume WIDTH = 32.
module cpu_datapath #(
    parameter int MEM_DEPTH = 512,
    parameter int WIDTH     = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               Gra,
    input  logic               Grb,
    input  logic               Grc,
    input  logic               Rin,
    input  logic               Rout,
    input  logic               BAout,
    input  logic               PCin,
    input  logic               IRin,
    input  logic               MARin,
    input  logic               MDRin,
    input  logic               Yin,
    input  logic               Zin,
    input  logic               HIin,
    input  logic               LOin,
    input  logic               PCout,
    input  logic               MDRout,
    input  logic               ZHIout,
    input  logic               ZLOout,
    input  logic               HIout,
    input  logic               LOout,
    input  logic               InPortout,
    input  logic               Cout,
    input  logic               IncPC,
    input  logic               MDRread,
    input  logic               WRen,
    input  logic               CONin,
    input  logic [4:0]         ALU_opcode,
    input  logic [WIDTH-1:0]   Mdatain,
    output logic [WIDTH-1:0]   bus_contents,
    output logic               CON,
    output logic [2*WIDTH-1:0] Z_register,
    output logic [WIDTH-1:0]   R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
    output logic [WIDTH-1:0]   R8,  R9,  R10, R11, R12, R13, R14, R15,
    output logic [WIDTH-1:0]   HI,
    output logic [WIDTH-1:0]   LO,
    output logic [WIDTH-1:0]   Y,
    output logic [WIDTH-1:0]   PC,
    output logic [WIDTH-1:0]   IR,
    output logic [WIDTH-1:0]   MAR,
    output logic [WIDTH-1:0]   MDR
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [WIDTH-1:0]   gpr_q [16];
    logic [WIDTH-1:0]   gpr_d [16];
    logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [WIDTH-1:0]   y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic               con_q, con_d;

    logic [WIDTH-1:0]   mem [MEM_DEPTH];
    logic [WIDTH-1:0]   mem_rd;
    logic [WIDTH-1:0]   bus;
    logic [3:0]         reg_sel;
    logic [2*WIDTH-1:0] alu_result;
    logic               cond;

    assign mem_rd = mem[mar_q[AW-1:0]];

    // Select/encode: OR together the IR register fields that are gated on
    assign reg_sel = ({4{Gra}} & ir_q[26:23])
                   | ({4{Grb}} & ir_q[22:19])
                   | ({4{Grc}} & ir_q[18:15]);

    // Bus mux with fixed priority; BAout reads R0 as zero for base addressing
    always_comb begin
        bus = '0;
        if (Rout || BAout) begin
            bus = (BAout && reg_sel == 4'd0) ? '0 : gpr_q[reg_sel];
        end else if (PCout) begin
            bus = pc_q;
        end else if (MDRout) begin
            bus = mdr_q;
        end else if (ZHIout) begin
            bus = z_q[2*WIDTH-1:WIDTH];
        end else if (ZLOout) begin
            bus = z_q[WIDTH-1:0];
        end else if (HIout) begin
            bus = hi_q;
        end else if (LOout) begin
            bus = lo_q;
        end else if (InPortout) begin
            bus = Mdatain;
        end else if (Cout) begin
            bus = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
        end
    end

    // ALU: A comes from Y, B from the bus; single-word results leave ZHI at zero
    always_comb begin
        logic [4:0]         sh;
        logic [2*WIDTH-1:0] dbl, ror_full, rol_full;
`ifdef ALU_MULDIV_EN
        logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
        logic signed [WIDTH-1:0]   sa, sb, quot, rem;
`endif
        alu_result = '0;
        sh         = bus[4:0];
        dbl        = {y_q, y_q};
        ror_full   = dbl >> sh;
        rol_full   = dbl << sh;
`ifdef ALU_MULDIV_EN
        a_ext = {{WIDTH{y_q[WIDTH-1]}}, y_q};
        b_ext = {{WIDTH{bus[WIDTH-1]}}, bus};
        prod  = a_ext * b_ext;
        sa    = y_q;
        sb    = bus;
        quot  = '0;
        rem   = '0;
        if (sb != '0) begin
            quot = sa / sb;
            rem  = sa % sb;
        end
`endif
        case (ALU_opcode)
            5'b00000: alu_result[WIDTH-1:0] = y_q + bus;
            5'b00001: alu_result[WIDTH-1:0] = y_q - bus;
            5'b00010: alu_result[WIDTH-1:0] = y_q & bus;
            5'b00011: alu_result[WIDTH-1:0] = y_q | bus;
            5'b00100: alu_result[WIDTH-1:0] = y_q >> sh;
            5'b00101: alu_result[WIDTH-1:0] = $signed(y_q) >>> sh;
            5'b00110: alu_result[WIDTH-1:0] = y_q << sh;
            5'b00111: alu_result[WIDTH-1:0] = ror_full[WIDTH-1:0];
            5'b01000: alu_result[WIDTH-1:0] = rol_full[2*WIDTH-1:WIDTH];
            5'b01001: alu_result[WIDTH-1:0] = -bus;
            5'b01010: alu_result[WIDTH-1:0] = ~bus;
`ifdef ALU_MULDIV_EN
            5'b01011: alu_result = prod;
            5'b01100: alu_result = {rem, quot};
`endif
            default:  alu_result = '0;
        endcase
    end

    // Branch condition chosen by IR C2 field, evaluated on the current bus
    always_comb begin
        cond = 1'b0;
        case (ir_q[20:19])
            2'b00: cond = (bus == '0);
            2'b01: cond = (bus != '0);
            2'b10: cond = ~bus[WIDTH-1];
            2'b11: cond = bus[WIDTH-1];
            default: cond = 1'b0;
        endcase
    end

    // Next-state for every register; loads always take the current bus value
    always_comb begin
        gpr_d = gpr_q;
        pc_d  = pc_q;
        ir_d  = ir_q;
        mar_d = mar_q;
        mdr_d = mdr_q;
        y_d   = y_q;
        z_d   = z_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        con_d = con_q;
        if (Rin)        gpr_d[reg_sel] = bus;
        if (PCin)       pc_d  = bus;
        else if (IncPC) pc_d  = pc_q + 1'b1;
        if (IRin)       ir_d  = bus;
        if (MARin)      mar_d = bus;
        if (MDRin)      mdr_d = MDRread ? mem_rd : bus;
        if (Yin)        y_d   = bus;
        if (Zin)        z_d   = alu_result;
        if (HIin)       hi_d  = bus;
        if (LOin)       lo_d  = bus;
        if (CONin)      con_d = cond;
    end

    // Register state, cleared immediately when clr goes low
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            con_q <= 1'b0;
        end else begin
            gpr_q <= gpr_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            con_q <= con_d;
        end
    end

    // RAM write uses the MDR value from before this edge; contents survive reset
    always_ff @(posedge clk) begin
        if (WRen) mem[mar_q[AW-1:0]] <= mdr_q;
    end

    assign bus_contents = bus;
    assign CON          = con_q;
    assign Z_register   = z_q;
    assign HI  = hi_q;
    assign LO  = lo_q;
    assign Y   = y_q;
    assign PC  = pc_q;
    assign IR  = ir_q;
    assign MAR = mar_q;
    assign MDR = mdr_q;
    assign R0  = gpr_q[0];
    assign R1  = gpr_q[1];
    assign R2  = gpr_q[2];
    assign R3  = gpr_q[3];
    assign R4  = gpr_q[4];
    assign R5  = gpr_q[5];
    assign R6  = gpr_q[6];
    assign R7  = gpr_q[7];
    assign R8  = gpr_q[8];
    assign R9  = gpr_q[9];
    assign R10 = gpr_q[10];
    assign R11 = gpr_q[11];
    assign R12 = gpr_q[12];
    assign R13 = gpr_q[13];
    assign R14 = gpr_q[14];
    assign R15 = gpr_q[15];

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed test of cpu_datapath with hand-computed expectations.
// Expected MUL/DIV results depend on ALU_MULDIV_EN in the same way as the design.
module tb_cpu_datapath;

    logic        clk, clr;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic        PCout, MDRout, ZHIout, ZLOout, HIout, LOout, InPortout, Cout;
    logic        IncPC, MDRread, WRen, CONin;
    logic [4:0]  ALU_opcode;
    logic [31:0] Mdatain;
    logic [31:0] bus_contents;
    logic        CON;
    logic [63:0] Z_register;
    logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
    logic [31:0] HI, LO, Y, PC, IR, MAR, MDR;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_datapath dut (
        .clk(clk), .clr(clr),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .PCout(PCout), .MDRout(MDRout), .ZHIout(ZHIout),
        .ZLOout(ZLOout), .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .IncPC(IncPC), .MDRread(MDRread), .WRen(WRen), .CONin(CONin),
        .ALU_opcode(ALU_opcode), .Mdatain(Mdatain),
        .bus_contents(bus_contents), .CON(CON), .Z_register(Z_register),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
        .R8(R8), .R9(R9), .R10(R10), .R11(R11), .R12(R12), .R13(R13), .R14(R14), .R15(R15),
        .HI(HI), .LO(LO), .Y(Y), .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearCtl();
        {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin} = '0;
        {PCout, MDRout, ZHIout, ZLOout, HIout, LOout, InPortout, Cout} = '0;
        {IncPC, MDRread, WRen, CONin} = '0;
        ALU_opcode = 5'b0;
        Mdatain    = 32'h0;
    endtask

    // Commit the currently driven strobes on one rising edge, then drop them
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearCtl();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic runAlu(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic [63:0] expected);
        Mdatain = a; InPortout = 1'b1; Yin = 1'b1;
        applyStimulus();
        Mdatain = b; InPortout = 1'b1; ALU_opcode = op; Zin = 1'b1;
        applyStimulus();
        checkOutput(tag, Z_register, expected);
    endtask

    initial begin
        logic [63:0] exp_mul, exp_div, exp_div0;
`ifdef ALU_MULDIV_EN
        exp_mul  = 64'hFFFFFFFF_FFFFFFF4;
        exp_div  = 64'hFFFFFFFF_FFFFFFFD;
`else
        exp_mul  = 64'h0;
        exp_div  = 64'h0;
`endif
        exp_div0 = 64'h0;

        clearCtl();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pc", {32'h0, PC}, 64'h0);
        checkOutput("reset_z", Z_register, 64'h0);
        checkOutput("reset_con", {63'h0, CON}, 64'h0);
        clr = 1'b1;
        checkOutput("idle_bus", {32'h0, bus_contents}, 64'h0);

        // Put the instruction word into RAM[0] through MAR/MDR
        Mdatain = 32'h0; InPortout = 1'b1; MARin = 1'b1; applyStimulus();
        Mdatain = 32'h01000001; InPortout = 1'b1; MDRin = 1'b1; applyStimulus();
        WRen = 1'b1; applyStimulus();
        Mdatain = 32'h0; InPortout = 1'b1; MDRin = 1'b1; applyStimulus();

        // Fetch
        PCout = 1'b1; MARin = 1'b1; applyStimulus();
        checkOutput("fetch_mar", {32'h0, MAR}, 64'h0);
        MDRread = 1'b1; MDRin = 1'b1; applyStimulus();
        checkOutput("fetch_mdr", {32'h0, MDR}, 64'h01000001);
        MDRout = 1'b1; IRin = 1'b1; applyStimulus();
        checkOutput("fetch_ir", {32'h0, IR}, 64'h01000001);

        // ADD R1 = R2 + R3 with IR Ra=1 Rb=2 Rc=3
        Mdatain = 32'h00918000; InPortout = 1'b1; IRin = 1'b1; applyStimulus();
        Mdatain = 32'd5; InPortout = 1'b1; Grb = 1'b1; Rin = 1'b1; applyStimulus();
        Mdatain = 32'd7; InPortout = 1'b1; Grc = 1'b1; Rin = 1'b1; applyStimulus();
        checkOutput("load_r2", {32'h0, R2}, 64'd5);
        checkOutput("load_r3", {32'h0, R3}, 64'd7);
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; applyStimulus();
        checkOutput("add_y", {32'h0, Y}, 64'd5);
        Grc = 1'b1; Rout = 1'b1; ALU_opcode = 5'b00000; Zin = 1'b1;
        #1;
        checkOutput("add_bus", {32'h0, bus_contents}, 64'd7);
        applyStimulus();
        checkOutput("add_z", Z_register, 64'd12);
        ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; applyStimulus();
        checkOutput("add_ra", {32'h0, R1}, 64'd12);
        Grc = 1'b1; Rout = 1'b1; ALU_opcode = 5'b00001; Zin = 1'b1; applyStimulus();
        checkOutput("sub_neg", Z_register, 64'h00000000_FFFFFFFE);

        // ALU vectors
        runAlu("add_wrap", 32'hFFFFFFFF, 32'd2, 5'b00000, 64'h1);
        runAlu("and", 32'h0000F0F0, 32'h0000FF00, 5'b00010, 64'hF000);
        runAlu("or", 32'h0000F0F0, 32'h0000FF00, 5'b00011, 64'hFFF0);
        runAlu("shr", 32'h80000010, 32'd4, 5'b00100, 64'h08000001);
        runAlu("shra", 32'h80000010, 32'd4, 5'b00101, 64'hF8000001);
        runAlu("shl", 32'h80000010, 32'd4, 5'b00110, 64'h00000100);
        runAlu("ror", 32'h00000013, 32'd4, 5'b00111, 64'h30000001);
        runAlu("rol", 32'h80000001, 32'd1, 5'b01000, 64'h00000003);
        runAlu("ror_by_32", 32'h12345678, 32'h20, 5'b00111, 64'h12345678);
        runAlu("shl_by_0", 32'h12345678, 32'h0, 5'b00110, 64'h12345678);
        runAlu("neg", 32'h0, 32'd1, 5'b01001, 64'hFFFFFFFF);
        runAlu("not", 32'h0, 32'h0F0F0F0F, 5'b01010, 64'hF0F0F0F0);
        runAlu("bad_op", 32'h1234, 32'h5678, 5'b01101, 64'h0);
        runAlu("div", 32'hFFFFFFF9, 32'd2, 5'b01100, exp_div);
        runAlu("div_by_0", 32'd100, 32'd0, 5'b01100, exp_div0);
        runAlu("mul", 32'hFFFFFFFD, 32'd4, 5'b01011, exp_mul);
        ZHIout = 1'b1; HIin = 1'b1; applyStimulus();
        ZLOout = 1'b1; LOin = 1'b1; applyStimulus();
        checkOutput("mul_hi", {32'h0, HI}, {32'h0, exp_mul[63:32]});
        checkOutput("mul_lo", {32'h0, LO}, {32'h0, exp_mul[31:0]});

        // Store then read back
        Mdatain = 32'h1F; InPortout = 1'b1; MARin = 1'b1; applyStimulus();
        Mdatain = 32'hDEADBEEF; InPortout = 1'b1; MDRin = 1'b1; applyStimulus();
        WRen = 1'b1; applyStimulus();
        Mdatain = 32'h0; InPortout = 1'b1; MDRin = 1'b1; applyStimulus();
        MDRread = 1'b1; MDRin = 1'b1; applyStimulus();
        checkOutput("store_read", {32'h0, MDR}, 64'hDEADBEEF);

        // Same-edge MDRin and WRen: RAM keeps the old MDR
        Mdatain = 32'h20; InPortout = 1'b1; MARin = 1'b1; applyStimulus();
        Mdatain = 32'h11111111; InPortout = 1'b1; MDRin = 1'b1; applyStimulus();
        Mdatain = 32'h22222222; InPortout = 1'b1; MDRin = 1'b1; WRen = 1'b1; applyStimulus();
        checkOutput("same_edge_mdr", {32'h0, MDR}, 64'h22222222);
        MDRread = 1'b1; MDRin = 1'b1; applyStimulus();
        checkOutput("same_edge_ram", {32'h0, MDR}, 64'h11111111);

        // R0 through Rout vs BAout, Cout sign extension, bus priority
        Mdatain = 32'h00040005; InPortout = 1'b1; IRin = 1'b1; applyStimulus();
        Mdatain = 32'h55; InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; applyStimulus();
        Gra = 1'b1; Rout = 1'b1; #1;
        checkOutput("rout_r0", {32'h0, bus_contents}, 64'h55);
        clearCtl(); Gra = 1'b1; BAout = 1'b1; #1;
        checkOutput("baout_r0", {32'h0, bus_contents}, 64'h0);
        clearCtl(); Cout = 1'b1; #1;
        checkOutput("cout_sext", {32'h0, bus_contents}, 64'hFFFC0005);
        clearCtl(); Gra = 1'b1; Rout = 1'b1; PCout = 1'b1; InPortout = 1'b1;
        Mdatain = 32'h77; #1;
        checkOutput("prio_rout", {32'h0, bus_contents}, 64'h55);
        clearCtl(); MDRout = 1'b1; InPortout = 1'b1; Mdatain = 32'h77; #1;
        checkOutput("prio_mdr", {32'h0, bus_contents}, 64'h11111111);
        clearCtl();

        // PC wrap and PCin priority over IncPC
        Mdatain = 32'hFFFFFFFF; InPortout = 1'b1; PCin = 1'b1; applyStimulus();
        IncPC = 1'b1; applyStimulus();
        checkOutput("pc_wrap", {32'h0, PC}, 64'h0);
        Mdatain = 32'h40; InPortout = 1'b1; PCin = 1'b1; IncPC = 1'b1; applyStimulus();
        checkOutput("pc_prio", {32'h0, PC}, 64'h40);

        // CON with C2=01 (non-zero) and C2=11 (negative)
        Mdatain = 32'h00080000; InPortout = 1'b1; IRin = 1'b1; applyStimulus();
        Mdatain = 32'd0; InPortout = 1'b1; CONin = 1'b1; applyStimulus();
        checkOutput("con_nz_0", {63'h0, CON}, 64'h0);
        Mdatain = 32'd9; InPortout = 1'b1; CONin = 1'b1; applyStimulus();
        checkOutput("con_nz_9", {63'h0, CON}, 64'h1);
        Mdatain = 32'h00180000; InPortout = 1'b1; IRin = 1'b1; applyStimulus();
        Mdatain = 32'd1; InPortout = 1'b1; CONin = 1'b1; applyStimulus();
        checkOutput("con_neg_pos", {63'h0, CON}, 64'h0);
        Mdatain = 32'h80000000; InPortout = 1'b1; CONin = 1'b1; applyStimulus();
        checkOutput("con_neg_neg", {63'h0, CON}, 64'h1);

        // Asynchronous reset mid-run, sampled away from any clock edge
        Mdatain = 32'h3; InPortout = 1'b1; Yin = 1'b1; applyStimulus();
        Mdatain = 32'h3; InPortout = 1'b1; Zin = 1'b1; applyStimulus();
        #2;
        clr = 1'b0;
        #1;
        checkOutput("arst_r1", {32'h0, R1}, 64'h0);
        checkOutput("arst_pc", {32'h0, PC}, 64'h0);
        checkOutput("arst_ir", {32'h0, IR}, 64'h0);
        checkOutput("arst_mdr", {32'h0, MDR}, 64'h0);
        checkOutput("arst_mar", {32'h0, MAR}, 64'h0);
        checkOutput("arst_y", {32'h0, Y}, 64'h0);
        checkOutput("arst_z", Z_register, 64'h0);
        checkOutput("arst_con", {63'h0, CON}, 64'h0);
        @(posedge clk);
        #1;
        clr = 1'b1;

        // RAM contents survive reset
        Mdatain = 32'h1F; InPortout = 1'b1; MARin = 1'b1; applyStimulus();
        MDRread = 1'b1; MDRin = 1'b1; applyStimulus();
        checkOutput("ram_keep", {32'h0, MDR}, 64'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
